// File: rtl/instruction_align.sv
// Fetch-to-decode aligner: buffers 16-bit fetch words in a small FIFO and presents
// complete 16-bit or prefixed 32-bit instructions to decode over valid/ready.
module instruction_align #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] fetch_word,
    input  logic [19:0] fetch_pc,
    input  logic        fetch_valid,
    output logic        fetch_stall,
    input  logic        flush,
    output logic [31:0] instr,
    output logic        instr_long,
    output logic [19:0] instr_pc,
    output logic        instr_valid,
    input  logic        decode_ready,
    output logic        overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        SHORT  = 2'd1,
        PREFIX = 2'd2,
        LONG   = 2'd3
    } head_state_t;

    logic [15:0]   word_mem_r [DEPTH];
    logic [19:0]   pc_mem_r   [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    head_state_t   head_state_s;
    logic [15:0]   head_word_s;
    logic [19:0]   head_pc_s;
    logic [15:0]   next_word_s;
    logic          push_s;
    logic          load_s;
    logic [CW-1:0] pops_s;

    assign fetch_stall = (count_r == CW'(DEPTH));

    // Head-of-FIFO view and classification of what the head word starts
    always_comb begin
        head_word_s = word_mem_r[rd_ptr_r];
        head_pc_s   = pc_mem_r[rd_ptr_r];
        next_word_s = word_mem_r[rd_ptr_r + PTR_ONE];
        if (count_r == {CW{1'b0}}) begin
            head_state_s = EMPTY;
        end else if (!head_word_s[15]) begin
            head_state_s = SHORT;
        end else if (count_r == CW'(1)) begin
            head_state_s = PREFIX;
        end else begin
            head_state_s = LONG;
        end
    end

    // Push/load decisions; the output register refills whenever it is empty or being drained
    always_comb begin
        push_s = fetch_valid && !fetch_stall && !flush;
        load_s = 1'b0;
        pops_s = {CW{1'b0}};
        case (head_state_s)
            SHORT: begin
                if ((!instr_valid || decode_ready) && !flush) begin
                    load_s = 1'b1;
                    pops_s = CW'(1);
                end else begin
                    load_s = 1'b0;
                end
            end
            LONG: begin
                if ((!instr_valid || decode_ready) && !flush) begin
                    load_s = 1'b1;
                    pops_s = CW'(2);
                end else begin
                    load_s = 1'b0;
                end
            end
            default: begin
                load_s = 1'b0;
                pops_s = {CW{1'b0}};
            end
        endcase
    end

    // Word storage; contents are only meaningful between the pointers, so no reset
    always_ff @(posedge clock) begin
        if (push_s) begin
            word_mem_r[wr_ptr_r] <= fetch_word;
            pc_mem_r[wr_ptr_r]   <= fetch_pc;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            rd_ptr_r <= rd_ptr_r + pops_s[AW-1:0];
            count_r  <= count_r + {{(CW-1){1'b0}}, push_s} - pops_s;
        end
    end

    // Output register presented to decode; holds while valid and not accepted
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr       <= 32'h0000_0000;
            instr_long  <= 1'b0;
            instr_pc    <= 20'h00000;
            instr_valid <= 1'b0;
        end else if (flush) begin
            instr_valid <= 1'b0;
        end else if (load_s) begin
            instr_valid <= 1'b1;
            instr_pc    <= head_pc_s;
            instr_long  <= (head_state_s == LONG);
            instr       <= (head_state_s == LONG) ? {head_word_s, next_word_s}
                                                  : {16'h0000, head_word_s};
        end else if (decode_ready) begin
            instr_valid <= 1'b0;
        end
    end

    // Sticky overflow: a word offered while full is lost; flush does not clear it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (fetch_valid && fetch_stall) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_align.sv
// Self-checking bench for instruction_align: directed scenarios plus randomized
// traffic compared each cycle against a queue-based reference model.
module tb_instruction_align;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic [15:0] fetch_word;
    logic [19:0] fetch_pc;
    logic        fetch_valid;
    logic        fetch_stall;
    logic        flush;
    logic [31:0] instr;
    logic        instr_long;
    logic [19:0] instr_pc;
    logic        instr_valid;
    logic        decode_ready;
    logic        overflow;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [15:0] w;
        logic [19:0] pc;
    } word_t;

    // Reference model: buffered words as a queue plus the presented instruction
    word_t       mq[$];
    logic        m_valid = 1'b0;
    logic        m_long  = 1'b0;
    logic        m_ovf   = 1'b0;
    logic        m_stall = 1'b0;
    logic [31:0] m_instr = 32'h0;
    logic [19:0] m_pc    = 20'h0;

    instruction_align #(.DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .fetch_word   (fetch_word),
        .fetch_pc     (fetch_pc),
        .fetch_valid  (fetch_valid),
        .fetch_stall  (fetch_stall),
        .flush        (flush),
        .instr        (instr),
        .instr_long   (instr_long),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .decode_ready (decode_ready),
        .overflow     (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock edge: drive inputs, advance the model by the behavioural rules, sample at edge+1
    task automatic cycle(input logic fv, input logic [15:0] w, input logic [19:0] pc,
                         input logic fl, input logic rdy);
        logic full_pre;
        logic complete;
        fetch_valid  = fv;
        fetch_word   = w;
        fetch_pc     = pc;
        flush        = fl;
        decode_ready = rdy;
        @(posedge clock);
        full_pre = (mq.size() == DEPTH);
        if (fv && full_pre) m_ovf = 1'b1;
        if (fl) begin
            mq.delete();
            m_valid = 1'b0;
        end else begin
            complete = (mq.size() >= 1) && (!mq[0].w[15] || mq.size() >= 2);
            if (complete && (!m_valid || rdy)) begin
                m_valid = 1'b1;
                m_pc    = mq[0].pc;
                if (mq[0].w[15]) begin
                    m_long  = 1'b1;
                    m_instr = {mq[0].w, mq[1].w};
                    void'(mq.pop_front());
                    void'(mq.pop_front());
                end else begin
                    m_long  = 1'b0;
                    m_instr = {16'h0000, mq[0].w};
                    void'(mq.pop_front());
                end
            end else if (rdy) begin
                m_valid = 1'b0;
            end
            if (fv && !full_pre) mq.push_back('{w: w, pc: pc});
        end
        m_stall = (mq.size() == DEPTH);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 16'h0000, 20'h00000, 1'b0, rdy);
    endtask

    task automatic model_clear();
        mq.delete();
        m_valid = 1'b0;
        m_long  = 1'b0;
        m_ovf   = 1'b0;
        m_stall = 1'b0;
        m_instr = 32'h0;
        m_pc    = 20'h0;
    endtask

    task automatic do_reset();
        #2;
        reset       = 1'b1;
        fetch_valid = 1'b0;
        flush       = 1'b0;
        model_clear();
        @(negedge clock);
        reset = 1'b0;
        idle(1'b0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 16'($urandom), 20'h00400 + 20'(i), 1'b0, 1'b0);
        compared++;
        if (overflow !== 1'b1) begin
            mismatched++;
            $display("FAIL pre_reset_overflow: got %b want 1", overflow);
        end
        #2;
        reset = 1'b1;
        fetch_valid = 1'b0;
        model_clear();
        #1;
        compared++;
        if ({instr_valid, instr, instr_long, instr_pc, overflow, fetch_stall} !== 56'h0) begin
            mismatched++;
            $display("FAIL reset_state: valid=%b instr=%h long=%b pc=%h ovf=%b stall=%b want all 0",
                     instr_valid, instr, instr_long, instr_pc, overflow, fetch_stall);
        end
        @(negedge clock);
        reset = 1'b0;
        idle(1'b1);
        cycle(1'b1, 16'h1234, 20'h00010, 1'b0, 1'b1);
        compared++;
        if (instr_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL short_latency_early: valid=%b want 0", instr_valid);
        end
        idle(1'b1);
        compared++;
        if ({instr_valid, instr, instr_long, instr_pc} !== {1'b1, 32'h0000_1234, 1'b0, 20'h00010}) begin
            mismatched++;
            $display("FAIL short_out: valid=%b instr=%h long=%b pc=%h want 1 00001234 0 00010",
                     instr_valid, instr, instr_long, instr_pc);
        end
        idle(1'b1);
        compared++;
        if (instr_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL short_drain: valid=%b want 0", instr_valid);
        end
    endtask

    task automatic test_prefix();
        cycle(1'b1, 16'h8A01, 20'h00020, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (instr_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL prefix_wait[%0d]: valid=%b want 0", i, instr_valid);
            end
            if (i < 3) idle(1'b1);
            else cycle(1'b1, 16'h8003, 20'h00021, 1'b0, 1'b1);
        end
        compared++;
        if (instr_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL prefix_second_push: valid=%b want 0", instr_valid);
        end
        idle(1'b1);
        compared++;
        if ({instr_valid, instr, instr_long, instr_pc} !== {1'b1, 32'h8A01_8003, 1'b1, 20'h00020}) begin
            mismatched++;
            $display("FAIL long_out: valid=%b instr=%h long=%b pc=%h want 1 8a018003 1 00020",
                     instr_valid, instr, instr_long, instr_pc);
        end
        idle(1'b1);
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, 16'h0100 + 16'(i), 20'h00200 + 20'(i), 1'b0, 1'b0);
            compared++;
            if (instr_valid !== m_valid || fetch_stall !== m_stall || overflow !== m_ovf ||
                (m_valid && ({instr, instr_long, instr_pc} !== {m_instr, m_long, m_pc}))) begin
                mismatched++;
                $display("FAIL full_fill[%0d]: valid=%b stall=%b ovf=%b instr=%h, want %b %b %b %h",
                         i, instr_valid, fetch_stall, overflow, instr, m_valid, m_stall, m_ovf, m_instr);
            end
        end
        compared++;
        if ({fetch_stall, overflow, instr_valid, instr} !== {1'b1, 1'b1, 1'b1, 32'h0000_0100}) begin
            mismatched++;
            $display("FAIL full_state: stall=%b ovf=%b valid=%b instr=%h want 1 1 1 00000100",
                     fetch_stall, overflow, instr_valid, instr);
        end
        for (int k = 0; k < 5; k++) begin
            compared++;
            if ({instr_valid, instr, instr_pc} !== {1'b1, 32'h0000_0100 + 32'(k), 20'h00200 + 20'(k)}) begin
                mismatched++;
                $display("FAIL full_drain[%0d]: valid=%b instr=%h pc=%h want 1 %h %h", k,
                         instr_valid, instr, instr_pc, 32'h0000_0100 + 32'(k), 20'h00200 + 20'(k));
            end
            idle(1'b1);
            compared++;
            if (fetch_stall !== 1'b0) begin
                mismatched++;
                $display("FAIL full_unstall[%0d]: stall=%b want 0", k, fetch_stall);
            end
        end
        compared++;
        if (instr_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL full_no_dup: valid=%b instr=%h want valid 0", instr_valid, instr);
        end
    endtask

    task automatic test_flush();
        cycle(1'b1, 16'h8A01, 20'h00030, 1'b0, 1'b1);
        cycle(1'b1, 16'h0005, 20'h00031, 1'b1, 1'b1);
        compared++;
        if ({instr_valid, fetch_stall, overflow} !== {1'b0, 1'b0, 1'b1}) begin
            mismatched++;
            $display("FAIL flush_state: valid=%b stall=%b ovf=%b want 0 0 1",
                     instr_valid, fetch_stall, overflow);
        end
        cycle(1'b1, 16'h0007, 20'h00100, 1'b0, 1'b1);
        idle(1'b1);
        compared++;
        if ({instr_valid, instr, instr_long, instr_pc} !== {1'b1, 32'h0000_0007, 1'b0, 20'h00100}) begin
            mismatched++;
            $display("FAIL post_flush_out: valid=%b instr=%h long=%b pc=%h want 1 00000007 0 00100",
                     instr_valid, instr, instr_long, instr_pc);
        end
        idle(1'b1);
    endtask

    task automatic test_interleave();
        logic [19:0] pc;
        logic        fv;
        logic        rdy;
        logic        p_valid;
        logic        p_rdy;
        logic [52:0] p_out;
        pc = 20'h01000;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            rdy     = c[0];
            fv      = ($urandom_range(0, 3) != 0) && !m_stall;
            p_valid = instr_valid;
            p_rdy   = rdy;
            p_out   = {instr, instr_long, instr_pc};
            cycle(fv, 16'($urandom), pc, 1'b0, rdy);
            if (fv) pc = pc + 20'h00001;
            compared++;
            if (instr_valid !== m_valid || fetch_stall !== m_stall || overflow !== m_ovf ||
                (m_valid && ({instr, instr_long, instr_pc} !== {m_instr, m_long, m_pc}))) begin
                mismatched++;
                $display("FAIL interleave[%0d]: valid=%b stall=%b ovf=%b instr=%h long=%b pc=%h, want %b %b %b %h %b %h",
                         c, instr_valid, fetch_stall, overflow, instr, instr_long, instr_pc,
                         m_valid, m_stall, m_ovf, m_instr, m_long, m_pc);
            end
            if (p_valid && !p_rdy) begin
                compared++;
                if (!instr_valid || {instr, instr_long, instr_pc} !== p_out) begin
                    mismatched++;
                    $display("FAIL hold_stable[%0d]: valid=%b out=%h want 1 %h",
                             c, instr_valid, {instr, instr_long, instr_pc}, p_out);
                end
            end
        end
        compared++;
        if (overflow !== 1'b0) begin
            mismatched++;
            $display("FAIL interleave_overflow: got %b want 0", overflow);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] words [20];
        int got;
        got = 0;
        do_reset();
        for (int i = 0; i < 20; i++) words[i] = 16'($urandom) & 16'h7FFF;
        for (int i = 0; i < 22; i++) begin
            if (i < 20) cycle(1'b1, words[i], 20'h00300 + 20'(i), 1'b0, 1'b1);
            else idle(1'b1);
            if (instr_valid && got < 20) begin
                compared++;
                if ({instr, instr_long, instr_pc} !== {16'h0000, words[got], 1'b0, 20'h00300 + 20'(got)}) begin
                    mismatched++;
                    $display("FAIL wrap[%0d]: instr=%h long=%b pc=%h want %h 0 %h", got,
                             instr, instr_long, instr_pc, {16'h0000, words[got]}, 20'h00300 + 20'(got));
                end
                got++;
            end
        end
        compared++;
        if (got !== 20) begin
            mismatched++;
            $display("FAIL wrap_count: delivered %0d want 20", got);
        end
    endtask

    initial begin
        reset        = 1'b1;
        fetch_valid  = 1'b0;
        fetch_word   = 16'h0000;
        fetch_pc     = 20'h00000;
        flush        = 1'b0;
        decode_ready = 1'b0;
        #12;
        reset = 1'b0;
        idle(1'b0);
        test_reset();
        test_prefix();
        test_full();
        test_flush();
        test_interleave();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instruction_align.md
# instruction_align

Sits between the fetch stage and decode in the 16-bit pipeline. Buffers 16-bit instruction words from fetch in a small FIFO, assembles 16-bit and 32-bit (prefixed) instructions, and presents one complete instruction plus its word address to decode through a valid/ready handshake. Provides back-pressure to fetch via `fetch_stall`, and discards all buffered state on a pipeline flush when a jump is taken.

## Interface

Parameters:
- `DEPTH`, default 4: word FIFO entries; power of two, 2..16.

Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `fetch_word`  in  16  instruction word from fetch (`fetchoutput`)
- `fetch_pc`  in  20  word address of `fetch_word`
- `fetch_valid`  in  1  `fetch_word`/`fetch_pc` valid this cycle
- `fetch_stall`  out  1  FIFO full; fetch must hold
- `flush`  in  1  discard all buffered and presented instructions (jump taken)
- `instr`  out  32  assembled instruction; 16-bit form in [15:0] with [31:16]=0; 32-bit form is {first word, second word}
- `instr_long`  out  1  `instr` is a 32-bit instruction
- `instr_pc`  out  20  address of the first word of `instr`
- `instr_valid`  out  1  output register holds an instruction
- `decode_ready`  in  1  decode accepts `instr` this cycle
- `overflow`  out  1  sticky error: push attempted while full

## Operation

- Push: when `fetch_valid && !fetch_stall && !flush`, write {`fetch_pc`, `fetch_word`} at the write pointer. Pointers are `$clog2(DEPTH)` bits and wrap modulo DEPTH. The count is `$clog2(DEPTH)+1` bits.
- `fetch_stall` = (count == DEPTH), registered-state derived (combinational from count only, with no path from `fetch_valid`).
- `fetch_valid && fetch_stall`: word dropped, `overflow` set to 1. Only reset clears `overflow`; `flush` does not.
- Head classification (FSM on FIFO head):
  - `EMPTY`: count == 0.
  - `SHORT`: head[15] == 0; the instruction is complete with 1 word.
  - `PREFIX`: head[15] == 1 and count == 1; waiting for the second word.
  - `LONG`: head[15] == 1 and count ≥ 2; the instruction is complete with 2 words.
- Output load: when the head state is `SHORT` or `LONG` and (`!instr_valid || decode_ready`) and `!flush`:
  - Load `instr`, `instr_long` and `instr_pc` (the head's pc), and set `instr_valid`.
  - Pop 1 word for `SHORT`, 2 words for `LONG`.
- Handshake: a transfer occurs on an edge where `instr_valid && decode_ready`. With no new load in that cycle, `instr_valid` clears. While `instr_valid && !decode_ready`, `instr`, `instr_long` and `instr_pc` hold stable.
- Count update in the same cycle: count_next = count + push − pops (pops ∈ {0,1,2}). A push into the slot freed by a pop in the same cycle is legal only if count < DEPTH before the edge.
- `flush` (synchronous, highest priority after reset):
  - Pointers and count go to 0, and `instr_valid` goes to 0.
  - Any push in the same cycle is discarded.
  - A partial `PREFIX` word is discarded.
- Reset, asserted at any time including mid-assembly: count, pointers, `instr`, `instr_pc`, `instr_long`, `instr_valid`, `overflow` and `fetch_stall` all go to 0 immediately.

## Timing

- Latency for a 16-bit word: pushed at edge N, `instr_valid` high after edge N+1. Minimum 2 cycles from presentation to decode visibility.
- Latency for a 32-bit instruction: `instr_valid` high the edge after the second word is pushed.
- Throughput: one instruction per cycle when `decode_ready` is held high and the FIFO is non-empty.
- Full: with `decode_ready` low, `fetch_stall` rises in the cycle after the DEPTH-th push. It falls in the cycle after the first pop.
- `flush`: the first word presented in the cycle after `flush` is accepted normally.

## Test plan

- Reset mid-stream, then push `0x1234` @ pc `0x00010` with `decode_ready`=1 -> two cycles later `instr_valid`=1, `instr`=`0x00001234`, `instr_long`=0, `instr_pc`=`0x00010`; the cycle after that `instr_valid`=0.
- Push `0x8A01` @ `0x00020`, idle 3 cycles, then push `0x8003` @ `0x00021` -> no `instr_valid` while in `PREFIX`; then `instr`=`0x8A018003`, `instr_long`=1, `instr_pc`=`0x00020`.
- `decode_ready`=0 with DEPTH=4, push 6 consecutive short words -> output holds word 0, FIFO fills, `fetch_stall`=1; the word offered while stalled without fetch holding sets `overflow`=1; raising `decode_ready` delivers the accepted words in order with no duplicates.
- Push `0x8A01` (`PREFIX`), then assert `flush` in the same cycle as pushing `0x0005` -> `instr_valid`=0 and count=0; the next push `0x0007` @ `0x00100` emerges as a 16-bit instruction at `instr_pc`=`0x00100`.
- Interleave short/long/short words with `decode_ready` toggling each cycle, including a same-cycle accept+load and a same-cycle push+2-word pop -> the scoreboard sees the exact instruction sequence and pcs, `instr` is stable while unaccepted, and `overflow` stays 0.
- Wrap: with DEPTH=4, stream 20 short words with `decode_ready`=1 -> pointers wrap 5 times and every word emerges in order with `instr_pc` incrementing by 1.
